// File: rtl/ddr5_req_queue_pkg.sv
// Shared types and address-map constants for the DDR5 request intake stage.
package ddr5_req_queue_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_TIME  = 2'd1,
    ST_WAIT_SPACE = 2'd2
  } stage_e;

  typedef struct packed {
    op_e         op;
    logic [3:0]  core;
    logic [15:0] row;
    logic [9:0]  col;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic        chan;
  } req_t;

  localparam int ADDR_W   = 34;
  localparam int ROW_MSB  = 33;
  localparam int ROW_LSB  = 18;
  localparam int COLH_MSB = 17;
  localparam int COLH_LSB = 12;
  localparam int BANK_MSB = 11;
  localparam int BANK_LSB = 10;
  localparam int BG_MSB   = 9;
  localparam int BG_LSB   = 7;
  localparam int CHAN_BIT = 6;
  localparam int COLL_MSB = 5;
  localparam int COLL_LSB = 2;

endpackage

// File: rtl/ddr5_req_queue_if.sv
// Request intake and head-of-queue bus of the DDR5 request queue.
interface ddr5_req_queue_if #(
  parameter int QUEUE_DEPTH = 16,
  parameter int TIME_W      = 64
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_cpu_cycle;
  logic [3:0]        in_core;
  logic [1:0]        in_op;
  logic [33:0]       in_addr;

  logic              head_valid;
  logic              head_ready;
  logic [1:0]        head_op;
  logic [3:0]        head_core;
  logic [15:0]       head_row;
  logic [9:0]        head_col;
  logic [2:0]        head_bg;
  logic [1:0]        head_bank;
  logic              head_chan;

  logic [TIME_W-1:0] now;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err_illegal_op;

  modport slave (
    input  in_valid, in_cpu_cycle, in_core, in_op, in_addr, head_ready,
    output in_ready, head_valid, head_op, head_core, head_row, head_col,
    output head_bg, head_bank, head_chan, now, count, full, empty, err_illegal_op
  );

  modport master (
    output in_valid, in_cpu_cycle, in_core, in_op, in_addr, head_ready,
    input  in_ready, head_valid, head_op, head_core, head_row, head_col,
    input  head_bg, head_bank, head_chan, now, count, full, empty, err_illegal_op
  );
endinterface

// File: rtl/ddr5_addr_decode.sv
// Combinational split of a 34-bit byte address into DDR5 coordinates.
module ddr5_addr_decode
  import ddr5_req_queue_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  op_e               op,
  input  logic [3:0]        core,
  output req_t              req
);
  // Bits [1:0] select a byte within a word and map to no DDR coordinate.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Field extraction from the fixed address map.
  always_comb begin
    req      = '0;
    req.op   = op;
    req.core = core;
    req.row  = addr[ROW_MSB:ROW_LSB];
    req.col  = {addr[COLH_MSB:COLH_LSB], addr[COLL_MSB:COLL_LSB]};
    req.bg   = addr[BG_MSB:BG_LSB];
    req.bank = addr[BANK_MSB:BANK_LSB];
    req.chan = addr[CHAN_BIT];
  end
endmodule

// File: rtl/ddr5_req_queue.sv
// DDR5 scheduler intake: holds each trace request until its arrival cycle,
// decodes the address and queues it in order for the command-timing stage.
// Optional feature macro: DDR5_REQ_QUEUE_BYPASS_EN -- present the staged
// request straight on the head outputs when the queue is empty.
module ddr5_req_queue
  import ddr5_req_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int TIME_W      = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  ddr5_req_queue_if.slave bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  stage_e            state, state_nxt;
  logic [TIME_W-1:0] now_q;
  logic [TIME_W-1:0] stg_cycle;
  logic [ADDR_W-1:0] stg_addr;
  logic [3:0]        stg_core;
  op_e               stg_op;
  req_t              stg_req;
  op_e               in_op_e;

  req_t              mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;

  logic fifo_valid, full_w, time_ok, byp_active, head_valid_w;
  logic pop, space, accept, release_w, byp_pop, push, fifo_pop;
  req_t head_req;

  assign in_op_e    = op_e'(bus.in_op);
  assign fifo_valid = (count_q != '0);
  assign full_w     = (count_q == CNT_W'(QUEUE_DEPTH));
  assign time_ok    = (now_q >= stg_cycle);

  ddr5_addr_decode u_decode (
    .addr (stg_addr),
    .op   (stg_op),
    .core (stg_core),
    .req  (stg_req)
  );

`ifdef DDR5_REQ_QUEUE_BYPASS_EN
  assign byp_active = !fifo_valid && (state != ST_IDLE) &&
                      ((state == ST_WAIT_SPACE) || time_ok);
`else
  assign byp_active = 1'b0;
`endif

  assign head_valid_w = fifo_valid || byp_active;
  assign pop          = head_valid_w && bus.head_ready;
  assign space        = !full_w || pop;

  // Staging FSM outputs: handshake, release and FIFO write/read strobes.
  always_comb begin
    bus.in_ready = (state == ST_IDLE);
    accept       = bus.in_valid && (state == ST_IDLE);
    release_w    = 1'b0;
    case (state)
      ST_WAIT_TIME:  release_w = time_ok && space;
      ST_WAIT_SPACE: release_w = space;
      default:       release_w = 1'b0;
    endcase
    byp_pop  = byp_active && bus.head_ready;
    push     = release_w && !byp_pop;
    fifo_pop = pop && fifo_valid;
  end

  // Staging FSM next-state: idle -> wait for arrival time -> wait for room.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (accept && (in_op_e != OP_ILLEGAL)) state_nxt = ST_WAIT_TIME;
      ST_WAIT_TIME:  if (time_ok) state_nxt = space ? ST_IDLE : ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (space) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Staging FSM state register; reset discards any staged request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Staged request fields, captured on every accepted handshake.
  always_ff @(posedge clock) begin
    if (accept) begin
      stg_cycle <= bus.in_cpu_cycle;
      stg_addr  <= bus.in_addr;
      stg_core  <= bus.in_core;
      stg_op    <= in_op_e;
    end
  end

  // Free-running cycle counter and the illegal-op pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      now_q <= '0;
      err_q <= 1'b0;
    end else begin
      now_q <= now_q + 1'b1;
      err_q <= accept && (in_op_e == OP_ILLEGAL);
    end
  end

  // FIFO storage, written with the decoded staged request on release.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= stg_req;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head selection: FIFO head, else the staged request when bypassing.
  always_comb begin
    head_req = '0;
    if (fifo_valid)      head_req = mem[rd_ptr];
    else if (byp_active) head_req = stg_req;
  end

  assign bus.head_valid     = head_valid_w;
  assign bus.head_op        = head_req.op;
  assign bus.head_core      = head_req.core;
  assign bus.head_row       = head_req.row;
  assign bus.head_col       = head_req.col;
  assign bus.head_bg        = head_req.bg;
  assign bus.head_bank      = head_req.bank;
  assign bus.head_chan      = head_req.chan;
  assign bus.now            = now_q;
  assign bus.count          = count_q;
  assign bus.full           = full_w;
  assign bus.empty          = !fifo_valid;
  assign bus.err_illegal_op = err_q;
endmodule

// File: tb/tb_ddr5_req_queue.sv
// Directed bench for ddr5_req_queue with a queue-level reference model.
module tb_ddr5_req_queue;
  localparam int DEPTH = 16;
`ifdef DDR5_REQ_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ddr5_req_queue_if #(.QUEUE_DEPTH(DEPTH), .TIME_W(64)) bus();

  ddr5_req_queue #(.QUEUE_DEPTH(DEPTH), .TIME_W(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  op;
    logic [3:0]  core;
    logic [33:0] addr;
    logic [63:0] cyc;
  } mreq_t;

  mreq_t       q[$];
  mreq_t       stg;
  bit          stg_v = 0;
  logic [63:0] now_m = 0;
  bit          err_m = 0;
  int          n0;
  bit          m_hv, m_pop, m_rel, m_acc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      stg_v = 0;
      now_m = 0;
      err_m = 0;
    end else begin
      n0    = q.size();
      m_hv  = (n0 > 0) || (BYP && stg_v && now_m >= stg.cyc);
      m_pop = m_hv && bus.head_ready;
      m_rel = stg_v && (now_m >= stg.cyc) && ((n0 < DEPTH) || m_pop);
      m_acc = !stg_v && bus.in_valid;
      if (m_pop && n0 > 0) void'(q.pop_front());
      if (m_rel) begin
        if (!(m_pop && n0 == 0)) q.push_back(stg);
        stg_v = 0;
      end
      err_m = m_acc && (bus.in_op == 2'd3);
      if (m_acc && bus.in_op != 2'd3) begin
        stg.op = bus.in_op; stg.core = bus.in_core;
        stg.addr = bus.in_addr; stg.cyc = bus.in_cpu_cycle;
        stg_v = 1;
      end
      now_m = now_m + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  mreq_t e;
  bit    e_hv;
  always @(negedge clock) begin
    if (reset_n) begin
      e_hv = (q.size() > 0) || (BYP && stg_v && now_m >= stg.cyc);
      chk("now", bus.now, now_m);
      chk("in_ready", bus.in_ready, !stg_v);
      chk("head_valid", bus.head_valid, e_hv);
      chk("count", bus.count, q.size());
      chk("full", bus.full, q.size() == DEPTH);
      chk("empty", bus.empty, q.size() == 0);
      chk("err_illegal_op", bus.err_illegal_op, err_m);
      if (e_hv) begin
        e = (q.size() > 0) ? q[0] : stg;
        chk("head_op", bus.head_op, e.op);
        chk("head_core", bus.head_core, e.core);
        chk("head_row", bus.head_row, e.addr[33:18]);
        chk("head_col", bus.head_col, {e.addr[17:12], e.addr[5:2]});
        chk("head_bg", bus.head_bg, e.addr[9:7]);
        chk("head_bank", bus.head_bank, e.addr[11:10]);
        chk("head_chan", bus.head_chan, e.addr[6]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_now(input logic [63:0] n);
    int t = 0;
    @(negedge clock);
    while (bus.now != n && t < 500) begin
      @(negedge clock);
      t++;
    end
    chk("wait_now_timeout", t >= 500, 0);
    #1;
  endtask

  task automatic send(input logic [63:0] cyc, input logic [3:0] core,
                      input logic [1:0] op, input logic [33:0] addr);
    int t = 0;
    while (!bus.in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    chk("send_timeout", t >= 300, 0);
    bus.in_valid = 1'b1; bus.in_cpu_cycle = cyc; bus.in_core = core;
    bus.in_op = op; bus.in_addr = addr;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc1();
    @(posedge clock); #1;
  endtask

  task automatic pop1();
    bus.head_ready = 1'b1;
    cyc1();
    bus.head_ready = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.head_ready = 1'b1;
    while (!bus.empty && t < 60) begin
      cyc1();
      t++;
    end
    bus.head_ready = 1'b0;
    chk("drain_empty", bus.empty, 1);
  endtask

  int c_before;

  initial begin
    bus.in_valid = 0; bus.in_cpu_cycle = '0; bus.in_core = '0;
    bus.in_op = '0; bus.in_addr = '0; bus.head_ready = 0;

    // Reset values
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_head_valid", bus.head_valid, 0);
    chk("rst_head_row", bus.head_row, 0);
    chk("rst_head_col", bus.head_col, 0);
    chk("rst_now", bus.now, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_err", bus.err_illegal_op, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Read offered at cycle 5 with the all-ones-style address
    wait_now(5);
    send(64'd5, 4'd1, 2'd0, 34'h3_FFFF_FFC0);
    chk("t1_hv_now6", bus.head_valid, BYP);
    cyc1();
    chk("t1_now", bus.now, 7);
    chk("t1_hv_now7", bus.head_valid, 1);
    chk("t1_row", bus.head_row, 16'hFFFF);
    chk("t1_col", bus.head_col, 10'h3F0);
    chk("t1_bg", bus.head_bg, 3'd7);
    chk("t1_bank", bus.head_bank, 2'd3);
    chk("t1_chan", bus.head_chan, 1);
    chk("t1_core", bus.head_core, 1);
    pop1();
    chk("t1_empty", bus.empty, 1);

    // Future arrival: held until now reaches 100
    wait_now(10);
    send(64'd100, 4'd2, 2'd1, 34'h1_2345_6788);
    wait_now(50);
    chk("t2_in_ready_50", bus.in_ready, 0);
    wait_now(100);
    chk("t2_in_ready_100", bus.in_ready, 0);
    chk("t2_hv_100", bus.head_valid, BYP);
    cyc1();
    chk("t2_hv_101", bus.head_valid, 1);
    chk("t2_in_ready_101", bus.in_ready, 1);
    chk("t2_op", bus.head_op, 1);
    pop1();

    // Fill to full, 17th waits for space, pop admits it on the same edge
    for (int i = 0; i < DEPTH; i++)
      send(64'd0, 4'(i), 2'(i % 3), 34'(i) * 34'h0_1357_9BC4 + 34'h2_0000_0040);
    cyc1(); cyc1();
    chk("t3_full", bus.full, 1);
    chk("t3_count", bus.count, 16);
    send(64'd0, 4'hA, 2'd2, 34'h0_ABCD_EF00);
    cyc1(); cyc1(); cyc1();
    chk("t3_wait_space", bus.in_ready, 0);
    chk("t3_count_wait", bus.count, 16);
    pop1();
    chk("t3_count_after", bus.count, 16);
    chk("t3_in_ready_after", bus.in_ready, 1);
    chk("t3_head_core1", bus.head_core, 1);
    drain();

    // Push and pop on the same edge at count==1
    send(64'd0, 4'd3, 2'd0, 34'h0_0000_1000);
    cyc1();
    chk("t4_count1", bus.count, 1);
    send(64'd0, 4'd5, 2'd2, 34'h2_4680_0A5C);
    pop1();
    chk("t4_count_same", bus.count, 1);
    chk("t4_head_new", bus.head_core, 5);
    chk("t4_head_op", bus.head_op, 2);
    drain();

    // Illegal op: dropped, one-cycle error pulse
    c_before = int'(bus.count);
    send(64'd0, 4'd7, 2'd3, 34'h0_1111_1110);
    chk("t5_err", bus.err_illegal_op, 1);
    chk("t5_in_ready", bus.in_ready, 1);
    chk("t5_count", bus.count, c_before);
    cyc1();
    chk("t5_err_off", bus.err_illegal_op, 0);

    // Reset while holding 5 entries and a staged request
    for (int i = 0; i < 5; i++) send(64'd0, 4'(i + 8), 2'd1, 34'(i) << 12);
    send(64'd5000, 4'd15, 2'd0, 34'h3_0000_0000);
    cyc1();
    chk("t6_count5", bus.count, 5);
    chk("t6_busy", bus.in_ready, 0);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("t6_count", bus.count, 0);
    chk("t6_empty", bus.empty, 1);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_head_valid", bus.head_valid, 0);
    chk("t6_now", bus.now, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc1();

`ifdef DDR5_REQ_QUEUE_BYPASS_EN
    // Bypass: request consumed straight from staging, count stays 0
    bus.head_ready = 1'b1;
    send(64'd0, 4'd9, 2'd1, 34'h1_0F0F_0F3C);
    chk("t7_hv", bus.head_valid, 1);
    chk("t7_count", bus.count, 0);
    chk("t7_core", bus.head_core, 9);
    cyc1();
    chk("t7_count_after", bus.count, 0);
    chk("t7_hv_after", bus.head_valid, 0);
    chk("t7_in_ready", bus.in_ready, 1);
    bus.head_ready = 1'b0;
`endif

    cyc1(); cyc1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
